cplx_product_sequencer: RTL

//  Front-end stage of the complex multiplier. Computes (a_re + j*a_im) * (b_re + j*b_im) for signed W-bit operands.
//  One sequential shift-add multiplier forms the four partial products ac, bd, ad and bc.
//  The stage then drives the 8-bit adder/subtractor to form re = ac - bd and im = ad + bc, and captures both results.

---
 rtl/cplx_mult_pkg.sv | 47 ++++
 rtl/cplx_product_sequencer_mul.sv | 69 ++++++
 rtl/cplx_product_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cplx_mult_pkg.sv
// Shared definitions for the complex-product front end.
//   W / PW   : operand width and product/result width (PW = 2*W)
//   CNT_W    : width of the shift-add iteration counters
//   state_t  : sequencer states
//   K_*      : partial product indices (ac, bd, ad, bc)
//   f_mag    : magnitude of a signed W-bit value as W-bit unsigned (-8 -> 8)
//   f_add_ovf: signed overflow of an addition given both addends and the sum
package cplx_mult_pkg;

    localparam int W     = 4;
    localparam int PW    = 8;
    localparam int CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        SGN     = 3'd2,
        COMB_RE = 3'd3,
        COMB_IM = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] K_AC = 2'd0;
    localparam logic [1:0] K_BD = 2'd1;
    localparam logic [1:0] K_AD = 2'd2;
    localparam logic [1:0] K_BC = 2'd3;

    // Two's complement magnitude; the most negative value maps to its
    // unsigned magnitude (4'b1000) because the result is read as unsigned.
    function automatic logic [W-1:0] f_mag(input logic [W-1:0] v);
        logic [W-1:0] m;
        if (v[W-1]) begin
            m = ~v + {{(W-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Overflow of x + y = s: operands agree in sign, sum does not.
    function automatic logic f_add_ovf(input logic [PW-1:0] x,
                                       input logic [PW-1:0] y,
                                       input logic [PW-1:0] s);
        return (x[PW-1] == y[PW-1]) && (s[PW-1] != x[PW-1]);
    endfunction

endpackage

// File: rtl/cplx_product_sequencer_mul.sv
// Sequential signed multiplier, reused for every partial product.
// A load (i_start) captures the operand magnitudes and the product sign.
// W cycles of radix-2 shift-add follow; in the next cycle o_done is high
// and o_p carries the sign-corrected product.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_start    : load new operands (may coincide with o_done)
//   i_x, i_y   : signed W-bit operands
//   o_done     : high for the sign-fix cycle; o_p valid then
//   o_p        : signed PW-bit product
module seq_mul_signed
    import cplx_mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic signed [W-1:0]  i_x,
    input  logic signed [W-1:0]  i_y,
    output logic                 o_done,
    output logic [PW-1:0]        o_p
);

    logic [PW-1:0]    r_mcand;
    logic [W-1:0]     r_mplier;
    logic [PW-1:0]    r_acc;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    // Operand load and shift-add iterations; r_done marks the sign-fix cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= {PW{1'b0}};
            r_mplier <= {W{1'b0}};
            r_acc    <= {PW{1'b0}};
            r_neg    <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mcand  <= {{(PW-W){1'b0}}, f_mag(i_x)};
                r_mplier <= f_mag(i_y);
                r_acc    <= {PW{1'b0}};
                r_neg    <= i_x[W-1] ^ i_y[W-1];
                r_cnt    <= {CNT_W{1'b0}};
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= {r_mcand[PW-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[W-1:1]};
                r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_cnt == CNT_W'(W-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    // Sign fix: the magnitude product is negated when operand signs differ.
    assign o_p    = r_neg ? (~r_acc + {{(PW-1){1'b0}}, 1'b1}) : r_acc;

endmodule

// File: rtl/cplx_product_sequencer.sv
// Front end of the complex multiplier: (a_re + j a_im) * (b_re + j b_im).
// Forms ac, bd, ad, bc with one reused sequential multiplier, then drives
// the external adder/subtractor for re = ac - bd and im = ad + bc.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   start                : request, sampled only in IDLE
//   a_re, a_im, b_re, b_im : signed W-bit operands, captured on accept
//   busy                 : operation in progress (cleared in the DONE cycle)
//   done                 : one-cycle pulse, results valid from this cycle
//   p_re, p_im, ovf      : results, held until the next operation writes them
//   as_a, as_b, as_sub   : adder/subtractor drive, zero outside combine cycles
//   as_res, as_co        : adder/subtractor result and carry (carry unused)
module cplx_product_sequencer
    import cplx_mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [W-1:0]  a_re,
    input  logic signed [W-1:0]  a_im,
    input  logic signed [W-1:0]  b_re,
    input  logic signed [W-1:0]  b_im,
    output logic                 busy,
    output logic                 done,
    output logic [PW-1:0]        p_re,
    output logic [PW-1:0]        p_im,
    output logic                 ovf,
    output logic [PW-1:0]        as_a,
    output logic [PW-1:0]        as_b,
    output logic                 as_sub,
    input  logic [PW-1:0]        as_res,
    input  logic                 as_co
);

    state_t               r_state;
    logic [1:0]           r_k;
    logic [CNT_W-1:0]     r_cnt;
    logic signed [W-1:0]  r_a_re;
    logic signed [W-1:0]  r_a_im;
    logic signed [W-1:0]  r_b_re;
    logic signed [W-1:0]  r_b_im;
    logic [PW-1:0]        r_prod [0:3];
    logic                 r_busy;
    logic                 r_done;
    logic [PW-1:0]        r_p_re;
    logic [PW-1:0]        r_p_im;
    logic                 r_ovf;
    logic [PW-1:0]        r_as_a;
    logic [PW-1:0]        r_as_b;
    logic                 r_as_sub;

    logic                 w_mul_start;
    logic signed [W-1:0]  w_mul_x;
    logic signed [W-1:0]  w_mul_y;
    logic                 w_mul_done;
    logic [PW-1:0]        w_mul_p;
    logic                 w_unused_co;

    // The carry-out has no role in signed result formation.
    assign w_unused_co = as_co;

    // Multiplier load: product 0 straight from the ports on accept (same edge
    // as operand capture), products 1..3 from the operand registers in SGN.
    always_comb begin
        w_mul_start = 1'b0;
        w_mul_x     = {W{1'b0}};
        w_mul_y     = {W{1'b0}};
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_mul_start = 1'b1;
                    w_mul_x     = a_re;
                    w_mul_y     = b_re;
                end else begin
                    w_mul_start = 1'b0;
                end
            end
            SGN: begin
                case (r_k)
                    K_AC: begin
                        w_mul_start = 1'b1;
                        w_mul_x     = r_a_im;
                        w_mul_y     = r_b_im;
                    end
                    K_BD: begin
                        w_mul_start = 1'b1;
                        w_mul_x     = r_a_re;
                        w_mul_y     = r_b_im;
                    end
                    K_AD: begin
                        w_mul_start = 1'b1;
                        w_mul_x     = r_a_im;
                        w_mul_y     = r_b_re;
                    end
                    default: begin
                        w_mul_start = 1'b0;
                    end
                endcase
            end
            default: begin
                w_mul_start = 1'b0;
            end
        endcase
    end

    seq_mul_signed u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mul_start),
        .i_x     (w_mul_x),
        .i_y     (w_mul_y),
        .o_done  (w_mul_done),
        .o_p     (w_mul_p)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= K_AC;
            r_cnt     <= {CNT_W{1'b0}};
            r_a_re    <= {W{1'b0}};
            r_a_im    <= {W{1'b0}};
            r_b_re    <= {W{1'b0}};
            r_b_im    <= {W{1'b0}};
            r_prod[0] <= {PW{1'b0}};
            r_prod[1] <= {PW{1'b0}};
            r_prod[2] <= {PW{1'b0}};
            r_prod[3] <= {PW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_p_re    <= {PW{1'b0}};
            r_p_im    <= {PW{1'b0}};
            r_ovf     <= 1'b0;
            r_as_a    <= {PW{1'b0}};
            r_as_b    <= {PW{1'b0}};
            r_as_sub  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_re  <= a_re;
                        r_a_im  <= a_im;
                        r_b_re  <= b_re;
                        r_b_im  <= b_im;
                        r_k     <= K_AC;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    // W cycles, aligned with the multiplier's iterations.
                    if (r_cnt == CNT_W'(W-1)) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= SGN;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                SGN: begin
                    if (w_mul_done) begin
                        r_prod[r_k] <= w_mul_p;
                        if (r_k == K_BC) begin
                            // prod[K_BC] not needed until COMB_IM, so the
                            // first combine uses only stored products.
                            r_as_a   <= r_prod[K_AC];
                            r_as_b   <= r_prod[K_BD];
                            r_as_sub <= 1'b1;
                            r_state  <= COMB_RE;
                        end else begin
                            r_k     <= r_k + 2'd1;
                            r_state <= MUL;
                        end
                    end else begin
                        // Multiplier out of step: abandon rather than store junk.
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                COMB_RE: begin
                    r_p_re   <= as_res;
                    r_as_a   <= r_prod[K_AD];
                    r_as_b   <= r_prod[K_BC];
                    r_as_sub <= 1'b0;
                    r_state  <= COMB_IM;
                end
                COMB_IM: begin
                    r_p_im   <= as_res;
                    r_ovf    <= f_add_ovf(r_prod[K_AD], r_prod[K_BC], as_res);
                    r_as_a   <= {PW{1'b0}};
                    r_as_b   <= {PW{1'b0}};
                    r_as_sub <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_as_a   <= {PW{1'b0}};
                    r_as_b   <= {PW{1'b0}};
                    r_as_sub <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign p_re   = r_p_re;
    assign p_im   = r_p_im;
    assign ovf    = r_ovf;
    assign as_a   = r_as_a;
    assign as_b   = r_as_b;
    assign as_sub = r_as_sub;

endmodule
